// File: rtl/clk_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// clk_ctrl_pkg : shared encodings for the clock front-panel controller
// Rev 1.0
// ============================================================================
package clk_ctrl_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_BTNS   = 7;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_ALARM     = 2'd1,
    MODE_STOPWATCH = 2'd2,
    MODE_COUNTDOWN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_VIEW = 2'd0,
    ST_EDIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    DIG_SEC1  = 3'd0,
    DIG_SEC10 = 3'd1,
    DIG_MIN1  = 3'd2,
    DIG_MIN10 = 3'd3,
    DIG_HR1   = 3'd4,
    DIG_HR10  = 3'd5
  } digit_e;

  // Button slots; BTN_NONE marks "no press this cycle".
  typedef enum logic [2:0] {
    BTN_MODE   = 3'd0,
    BTN_MODIFY = 3'd1,
    BTN_UP     = 3'd2,
    BTN_DOWN   = 3'd3,
    BTN_LEFT   = 3'd4,
    BTN_RIGHT  = 3'd5,
    BTN_START  = 3'd6,
    BTN_NONE   = 3'd7
  } btn_e;

  // Move the edit cursor one digit, wrapping across the six digits.
  function automatic logic [2:0] cursor_step(input logic [2:0] cur, input logic fwd);
    logic [2:0] nxt;
    if (fwd) nxt = (cur == 3'(DIG_HR10)) ? 3'(DIG_SEC1) : cur + 3'd1;
    else     nxt = (cur == 3'(DIG_SEC1)) ? 3'(DIG_HR10) : cur - 3'd1;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_mode_ctrl_btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// btn_debounce : 2-flop synchronizer, stability counter, rising-edge press strobe
// Rev 1.0
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      // The level flips only after a full DEBOUNCE_CYC run of disagreement.
      if (sync2_q != stable_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYC)) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/timer_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// timer_mode_ctrl : button debounce, mode/edit/run FSM and digit blink control
// Rev 1.0
// ============================================================================
module timer_mode_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       modify,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       cd_zero,
  output logic [1:0] mode_sel,
  output logic       edit,
  output logic [2:0] cursor,
  output logic [5:0] inc_pulse,
  output logic [5:0] dec_pulse,
  output logic       sw_clr,
  output logic       cd_clr,
  output logic       sw_run,
  output logic       cd_run,
  output logic       cd_done,
  output logic [5:0] blink_mask
);

  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [NUM_BTNS-1:0]   w_raw, w_press;
  btn_e                  w_win;
  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [2:0]            cursor_q, cursor_d;
  logic [NUM_DIGITS-1:0] inc_q, inc_d, dec_q, dec_d;
  logic                  sw_clr_q, sw_clr_d, cd_clr_q, cd_clr_d;
  logic                  w_blink_clr;
  logic [BW-1:0]         blink_cnt_q;
  logic                  phase_q;

  assign w_raw = {start, right, left, down, up, modify, mode};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (w_raw[i]),
      .press_o (w_press[i])
    );
  end

  always_comb begin
    w_win = BTN_NONE;
    if      (w_press[BTN_START])  w_win = BTN_START;
    else if (w_press[BTN_MODIFY]) w_win = BTN_MODIFY;
    else if (w_press[BTN_MODE])   w_win = BTN_MODE;
    else if (w_press[BTN_LEFT])   w_win = BTN_LEFT;
    else if (w_press[BTN_RIGHT])  w_win = BTN_RIGHT;
    else if (w_press[BTN_UP])     w_win = BTN_UP;
    else if (w_press[BTN_DOWN])   w_win = BTN_DOWN;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cursor_d    = cursor_q;
    inc_d       = '0;
    dec_d       = '0;
    sw_clr_d    = 1'b0;
    cd_clr_d    = 1'b0;
    w_blink_clr = 1'b0;
    case (state_q)
      ST_VIEW: begin
        case (w_win)
          BTN_MODE:   mode_d = mode_e'(mode_q + 2'd1);
          BTN_MODIFY: if (mode_q != MODE_STOPWATCH) begin
            state_d     = ST_EDIT;
            cursor_d    = 3'(DIG_SEC1);
            w_blink_clr = 1'b1;
          end
          BTN_START: if (mode_q == MODE_STOPWATCH ||
                         (mode_q == MODE_COUNTDOWN && !cd_zero)) state_d = ST_RUN;
          BTN_DOWN: begin
            sw_clr_d = (mode_q == MODE_STOPWATCH);
            cd_clr_d = (mode_q == MODE_COUNTDOWN);
          end
          default: ;
        endcase
      end
      ST_EDIT: begin
        case (w_win)
          BTN_LEFT: begin
            cursor_d    = cursor_step(cursor_q, 1'b1);
            w_blink_clr = 1'b1;
          end
          BTN_RIGHT: begin
            cursor_d    = cursor_step(cursor_q, 1'b0);
            w_blink_clr = 1'b1;
          end
          BTN_UP:     inc_d[cursor_q] = 1'b1;
          BTN_DOWN:   dec_d[cursor_q] = 1'b1;
          BTN_MODIFY: state_d = ST_VIEW;
          default: ;
        endcase
      end
      ST_RUN: begin
        // Expiry wins over a pause press landing on the same cycle.
        if (mode_q == MODE_COUNTDOWN && cd_zero) state_d = ST_DONE;
        else if (w_win == BTN_START)             state_d = ST_VIEW;
      end
      ST_DONE: if (w_win != BTN_NONE) state_d = ST_VIEW;
      default: state_d = ST_VIEW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_VIEW;
      mode_q   <= MODE_CLOCK;
      cursor_q <= 3'(DIG_SEC1);
      inc_q    <= '0;
      dec_q    <= '0;
      sw_clr_q <= 1'b0;
      cd_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      sw_clr_q <= sw_clr_d;
      cd_clr_q <= cd_clr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_blink_clr) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  always_comb begin
    blink_mask = '0;
    if (state_q == ST_EDIT)      blink_mask[cursor_q] = phase_q;
    else if (state_q == ST_DONE) blink_mask = {NUM_DIGITS{phase_q}};
  end

  assign mode_sel  = mode_q;
  assign edit      = (state_q == ST_EDIT);
  assign cursor    = cursor_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign sw_clr    = sw_clr_q;
  assign cd_clr    = cd_clr_q;
  assign sw_run    = (state_q == ST_RUN) && (mode_q == MODE_STOPWATCH);
  assign cd_run    = (state_q == ST_RUN) && (mode_q == MODE_COUNTDOWN);
  assign cd_done   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_timer_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_timer_mode_ctrl : directed scenarios plus randomized presses vs a press-level model
// Rev 1.0
// ============================================================================
module tb_timer_mode_ctrl;

  localparam int D  = 4;
  localparam int BD = 8;
  localparam int B_MODE = 0, B_MODIFY = 1, B_UP = 2, B_DOWN = 3,
                 B_LEFT = 4, B_RIGHT = 5, B_START = 6;

  logic       clk = 1'b0, reset = 1'b1, cd_zero = 1'b0;
  logic [6:0] btn = '0;
  logic [1:0] mode_sel;
  logic       edit, sw_clr, cd_clr, sw_run, cd_run, cd_done;
  logic [2:0] cursor;
  logic [5:0] inc_pulse, dec_pulse, blink_mask;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  timer_mode_ctrl #(.DEBOUNCE_CYC(D), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .mode(btn[B_MODE]), .modify(btn[B_MODIFY]), .up(btn[B_UP]), .down(btn[B_DOWN]),
    .left(btn[B_LEFT]), .right(btn[B_RIGHT]), .start(btn[B_START]), .cd_zero(cd_zero),
    .mode_sel(mode_sel), .edit(edit), .cursor(cursor),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .sw_clr(sw_clr), .cd_clr(cd_clr),
    .sw_run(sw_run), .cd_run(cd_run), .cd_done(cd_done), .blink_mask(blink_mask)
  );

  // Strobe monitor: counts high cycles per digit and per clear line.
  int         inc_cnt[6], dec_cnt[6];
  int         inc_tot, dec_tot, swclr_tot, cdclr_tot;
  logic [5:0] inc_last, dec_last;
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin inc_cnt[i] = 0; dec_cnt[i] = 0; end
      inc_tot = 0; dec_tot = 0; swclr_tot = 0; cdclr_tot = 0;
      inc_last = '0; dec_last = '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        inc_cnt[i] += int'(inc_pulse[i]);
        dec_cnt[i] += int'(dec_pulse[i]);
      end
      if (inc_pulse != 0) begin inc_tot++; inc_last = inc_pulse; end
      if (dec_pulse != 0) begin dec_tot++; dec_last = dec_pulse; end
      swclr_tot += int'(sw_clr);
      cdclr_tot += int'(cd_clr);
    end
  end

  // Press-level reference model: st 0=view 1=edit 2=run 3=done.
  int m_mode, m_st, m_cur, m_sw, m_cd;
  int m_inc[6], m_dec[6];

  function automatic void model_reset();
    m_mode = 0; m_st = 0; m_cur = 0; m_sw = 0; m_cd = 0;
    for (int i = 0; i < 6; i++) begin m_inc[i] = 0; m_dec[i] = 0; end
  endfunction

  function automatic int winner(input logic [6:0] m);
    int pri[7] = '{B_START, B_MODIFY, B_MODE, B_LEFT, B_RIGHT, B_UP, B_DOWN};
    for (int k = 0; k < 7; k++) if (m[pri[k]]) return pri[k];
    return -1;
  endfunction

  function automatic void model_press(input logic [6:0] m, input logic cz);
    int w = winner(m);
    if (w < 0) return;
    case (m_st)
      0: begin
        if (w == B_MODE) m_mode = (m_mode + 1) % 4;
        else if (w == B_MODIFY && m_mode != 2) begin m_st = 1; m_cur = 0; end
        else if (w == B_START && (m_mode == 2 || (m_mode == 3 && !cz))) m_st = 2;
        else if (w == B_DOWN && m_mode == 2) m_sw++;
        else if (w == B_DOWN && m_mode == 3) m_cd++;
      end
      1: begin
        if (w == B_LEFT)        m_cur = (m_cur + 1) % 6;
        else if (w == B_RIGHT)  m_cur = (m_cur + 5) % 6;
        else if (w == B_UP)     m_inc[m_cur]++;
        else if (w == B_DOWN)   m_dec[m_cur]++;
        else if (w == B_MODIFY) m_st = 0;
      end
      2: if (w == B_START) m_st = 0;
      default: m_st = 0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [6:0] m);
    @(negedge clk) btn = m;
    repeat (2*D + 6) @(posedge clk);
    @(negedge clk) btn = '0;
    tick(2*D + 6);
    model_press(m, cd_zero);
  endtask

  task automatic do_reset();
    @(negedge clk) begin reset = 1'b1; btn = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    tick(2);
    n_total++;
    if ({mode_sel, edit, cursor, inc_pulse, dec_pulse, sw_clr, cd_clr, sw_run, cd_run, cd_done, blink_mask} !== 29'd0)
      $display("FAIL reset_outputs: got mode=%0d edit=%b cur=%0d run=%b%b done=%b blink=%h, want all zero",
               mode_sel, edit, cursor, sw_run, cd_run, cd_done, blink_mask);
    else n_pass++;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_mode_cycle();
    logic [1:0] at8, at9;
    @(negedge clk) btn[B_MODE] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 8) at8 = mode_sel;
      if (i == 9) at9 = mode_sel;
    end
    n_total++;
    if (at8 !== 2'd0 || at9 !== 2'd1) $display("FAIL mode_latency: got %0d,%0d at edges 8,9 want 0,1", at8, at9);
    else n_pass++;
    @(negedge clk) btn = '0;
    tick(2*D + 6);
    n_total++;
    if (mode_sel !== 2'd1) $display("FAIL mode_once: got %0d want 1", mode_sel); else n_pass++;
    for (int k = 2; k <= 4; k++) begin
      press(7'(1) << B_MODE);
      n_total++;
      if (mode_sel !== 2'(k % 4)) $display("FAIL mode_wrap: got %0d want %0d", mode_sel, k % 4);
      else n_pass++;
    end
  endtask

  task automatic test_edit();
    int t_inc, t_dec, got;
    logic [5:0] b7, b8;
    repeat (3) press(7'(1) << B_MODE);
    @(negedge clk) btn[B_MODIFY] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin @(posedge clk); #1; got = int'(edit); end
    tick(7); b7 = blink_mask;
    tick(1); b8 = blink_mask;
    n_total++;
    if (got != 1 || cursor !== 3'd0 || b7 !== 6'b000000 || b8 !== 6'b000001)
      $display("FAIL edit_entry_blink: got edit=%0d cur=%0d blink7=%b blink8=%b want 1 0 000000 000001", got, cursor, b7, b8);
    else n_pass++;
    @(negedge clk) btn = '0;
    tick(2*D + 6);
    press(7'(1) << B_LEFT);
    n_total++;
    if (cursor !== 3'd1) $display("FAIL edit_left: got %0d want 1", cursor); else n_pass++;
    repeat (5) press(7'(1) << B_LEFT);
    n_total++;
    if (cursor !== 3'd0) $display("FAIL edit_left_wrap: got %0d want 0", cursor); else n_pass++;
    t_inc = inc_tot;
    press(7'(1) << B_UP);
    n_total++;
    if (inc_tot != t_inc + 1 || inc_last !== 6'b000001)
      $display("FAIL edit_inc: got %0d cycles last=%b want 1 cycle 000001", inc_tot - t_inc, inc_last);
    else n_pass++;
    press(7'(1) << B_RIGHT);
    n_total++;
    if (cursor !== 3'd5) $display("FAIL edit_right_wrap: got %0d want 5", cursor); else n_pass++;
    t_dec = dec_tot;
    press(7'(1) << B_DOWN);
    n_total++;
    if (dec_tot != t_dec + 1 || dec_last !== 6'b100000)
      $display("FAIL edit_dec: got %0d cycles last=%b want 1 cycle 100000", dec_tot - t_dec, dec_last);
    else n_pass++;
    press(7'(1) << B_MODIFY);
    n_total++;
    if (edit !== 1'b0 || cursor !== 3'd5) $display("FAIL edit_exit: got edit=%b cur=%0d want 0 5", edit, cursor);
    else n_pass++;
  endtask

  task automatic test_countdown();
    int t_cd, bad, flips, runlen;
    logic [5:0] prev;
    cd_zero = 1'b1;
    press(7'(1) << B_START);
    n_total++;
    if (cd_run !== 1'b0) $display("FAIL cd_start_at_zero: got cd_run=%b want 0", cd_run); else n_pass++;
    cd_zero = 1'b0;
    t_cd = cdclr_tot;
    press(7'(1) << B_DOWN);
    n_total++;
    if (cdclr_tot != t_cd + 1) $display("FAIL cd_clr: got %0d cycles want 1", cdclr_tot - t_cd); else n_pass++;
    press(7'(1) << B_START);
    n_total++;
    if (cd_run !== 1'b1 || sw_run !== 1'b0) $display("FAIL cd_run: got cd=%b sw=%b want 1 0", cd_run, sw_run);
    else n_pass++;
    @(negedge clk) cd_zero = 1'b1;
    tick(1);
    n_total++;
    if (cd_run !== 1'b0 || cd_done !== 1'b1) $display("FAIL cd_expire: got run=%b done=%b want 0 1", cd_run, cd_done);
    else n_pass++;
    bad = 0; flips = 0; runlen = 0; prev = blink_mask;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (blink_mask !== 6'h00 && blink_mask !== 6'h3f) bad++;
      if (blink_mask !== prev) begin
        if (flips > 0 && runlen != BD) bad++;
        flips++; runlen = 1; prev = blink_mask;
      end else runlen++;
    end
    n_total++;
    if (bad != 0 || flips < 3) $display("FAIL done_blink: got bad=%0d flips=%0d want 0 and >=3", bad, flips);
    else n_pass++;
    press(7'(1) << B_UP);
    n_total++;
    if (cd_done !== 1'b0 || cd_run !== 1'b0 || edit !== 1'b0 || blink_mask !== 6'h00)
      $display("FAIL done_exit: got done=%b run=%b edit=%b blink=%h want 0 0 0 00", cd_done, cd_run, edit, blink_mask);
    else n_pass++;
    cd_zero = 1'b0;
  endtask

  task automatic test_stopwatch();
    int t_sw;
    repeat (3) press(7'(1) << B_MODE);
    press(7'(1) << B_MODIFY);
    n_total++;
    if (mode_sel !== 2'd2 || edit !== 1'b0) $display("FAIL sw_modify: got mode=%0d edit=%b want 2 0", mode_sel, edit);
    else n_pass++;
    press(7'(1) << B_START);
    n_total++;
    if (sw_run !== 1'b1 || cd_run !== 1'b0) $display("FAIL sw_run: got sw=%b cd=%b want 1 0", sw_run, cd_run);
    else n_pass++;
    press(7'(1) << B_START);
    n_total++;
    if (sw_run !== 1'b0) $display("FAIL sw_pause: got %b want 0", sw_run); else n_pass++;
    t_sw = swclr_tot;
    press(7'(1) << B_DOWN);
    n_total++;
    if (swclr_tot != t_sw + 1) $display("FAIL sw_clr: got %0d cycles want 1", swclr_tot - t_sw); else n_pass++;
  endtask

  task automatic test_priority_glitch();
    int t_inc;
    press(7'(1) << B_MODE);
    press((7'(1) << B_START) | (7'(1) << B_MODIFY));
    n_total++;
    if (cd_run !== 1'b1 || edit !== 1'b0) $display("FAIL prio_start: got run=%b edit=%b want 1 0", cd_run, edit);
    else n_pass++;
    press(7'(1) << B_START);
    press(7'(1) << B_MODIFY);
    t_inc = inc_tot;
    @(negedge clk) btn[B_UP] = 1'b1;
    repeat (2) @(negedge clk);
    btn = '0;
    tick(20);
    n_total++;
    if (inc_tot != t_inc || edit !== 1'b1) $display("FAIL glitch: got %0d inc cycles edit=%b want 0 1", inc_tot - t_inc, edit);
    else n_pass++;
    press(7'(1) << B_MODIFY);
  endtask

  task automatic test_reset_midop();
    int early, fc;
    press(7'(1) << B_START);
    @(negedge clk) reset = 1'b1;
    tick(1);
    n_total++;
    if ({mode_sel, edit, cursor, sw_run, cd_run, cd_done} !== 9'd0)
      $display("FAIL reset_run: got mode=%0d edit=%b run=%b want all zero", mode_sel, edit, cd_run);
    else n_pass++;
    @(negedge clk) reset = 1'b0;
    press(7'(1) << B_MODIFY);
    press(7'(1) << B_LEFT);
    @(negedge clk) begin btn[B_MODE] = 1'b1; reset = 1'b1; end
    tick(1);
    n_total++;
    if ({edit, cursor, blink_mask, mode_sel} !== 12'd0)
      $display("FAIL reset_edit: got edit=%b cur=%0d blink=%h want all zero", edit, cursor, blink_mask);
    else n_pass++;
    @(negedge clk) reset = 1'b0;
    early = 0; fc = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i <= 6 && mode_sel !== 2'd0) early++;
      if (fc == 0 && mode_sel === 2'd1) fc = i;
    end
    @(negedge clk) btn = '0;
    tick(2*D + 6);
    n_total++;
    if (early != 0 || fc < 7 || fc > 10 || mode_sel !== 2'd1)
      $display("FAIL held_through_reset: got first change edge %0d early=%0d mode=%0d want 7..10 0 1", fc, early, mode_sel);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] m;
    logic [8:0] expv, gotv;
    int bad;
    do_reset();
    for (int n = 0; n < 50; n++) begin
      m = 7'(1) << $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) m = m | (7'(1) << $urandom_range(0, 6));
      press(m);
      expv = {2'(m_mode), m_st == 1, 3'(m_cur), m_st == 2 && m_mode == 2, m_st == 2 && m_mode == 3, m_st == 3};
      gotv = {mode_sel, edit, cursor, sw_run, cd_run, cd_done};
      n_total++;
      if (gotv !== expv) $display("FAIL rand_state[%0d] btn=%b: got %h want %h", n, m, gotv, expv);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 6; i++) if (inc_cnt[i] != m_inc[i] || dec_cnt[i] != m_dec[i]) bad++;
      if (swclr_tot != m_sw || cdclr_tot != m_cd) bad++;
      n_total++;
      if (bad != 0) $display("FAIL rand_strobes[%0d] btn=%b: got %0d count mismatches want 0", n, m, bad);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_cycle();
    test_edit();
    test_countdown();
    test_stopwatch();
    test_priority_glitch();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/timer_mode_ctrl.md
# timer_mode_ctrl

Front-panel controller for the clock design. It debounces the seven push buttons and tracks the active mode (clock, alarm, stopwatch, countdown) and the view/edit/run/done sequencing. It turns button presses into one-cycle per-digit increment/decrement, clear and run controls for the digit datapaths, and drives the digit blink mask for the display mux.

## Interface
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required before a synchronized button level is accepted (10 ms at 100 MHz).
- BLINK_DIV, 25_000_000: cycles per blink half-period.
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high; one clock, all state on posedge clk.
- mode, modify, up, down, left, right, start  in  1 each  raw asynchronous buttons, active-high.
- cd_zero  in  1  countdown datapath reports all six digits zero.
- mode_sel  out  2  0=CLOCK, 1=ALARM, 2=STOPWATCH, 3=COUNTDOWN; reset 0.
- edit  out  1  high in EDIT state; reset 0.
- cursor  out  3  edited digit, 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hr_1, 5=hr_10; reset 0.
- inc_pulse, dec_pulse  out  6 each  one-hot one-cycle digit strobes; reset 0.
- sw_clr, cd_clr  out  1 each  one-cycle clear strobes; reset 0.
- sw_run, cd_run  out  1 each  run enables (levels); reset 0.
- cd_done  out  1  countdown-expired level; reset 0.
- blink_mask  out  6  1 = blank that digit; reset 0.

## Operation
- Per button: 2-flop synchronizer, then debounce counter. The stable level flips after DEBOUNCE_CYC consecutive cycles of disagreement. A rising edge of the stable level gives a one-cycle registered press strobe. Falling edges produce nothing.
- Press priority when several strobes coincide: start > modify > mode > left > right > up > down. Only the winner is acted on; the rest are discarded.
- The FSM has four states: VIEW (reset state), EDIT, RUN and DONE.
- VIEW:
  - mode: mode_sel+1, wrapping 3→0.
  - modify: go to EDIT with cursor=0, but only when mode_sel≠STOPWATCH; otherwise ignored.
  - start: go to RUN when mode_sel=STOPWATCH, or when mode_sel=COUNTDOWN and cd_zero=0; otherwise ignored.
  - down: in STOPWATCH pulse sw_clr; in COUNTDOWN pulse cd_clr; otherwise ignored.
- EDIT:
  - left: cursor+1, wrapping 5→0.
  - right: cursor−1, wrapping 0→5.
  - up: inc_pulse[cursor]=1 for one cycle.
  - down: dec_pulse[cursor]=1 for one cycle.
  - modify: go to VIEW; cursor keeps its value.
  - start and mode are ignored.
- RUN:
  - sw_run = (mode_sel==STOPWATCH); cd_run = (mode_sel==COUNTDOWN).
  - start: go to VIEW (pause).
  - In COUNTDOWN, cd_zero sampled high goes to DONE. This check has priority over start in the same cycle.
  - All other presses are ignored.
- DONE:
  - cd_done=1; all run outputs are 0.
  - Any press returns to VIEW and clears cd_done.
- Blink:
  - A free-running counter toggles a phase bit every BLINK_DIV cycles.
  - The counter and phase (0 = visible) are cleared on entering EDIT and on every cursor move.
  - In EDIT, blink_mask[cursor]=phase and all other bits are 0.
  - In DONE, all six bits equal phase.
  - Otherwise blink_mask=0.
- Reset mid-operation:
  - Next edge: all outputs take their reset values, the FSM goes to VIEW, debounced levels go to 0 and counters clear.
  - A button held through reset yields one press DEBOUNCE_CYC+3 edges after reset deasserts.

## Timing
- Raw rise first sampled at edge e:
  - synchronized level at e+2;
  - stable level at e+2+DEBOUNCE_CYC;
  - press strobe at e+3+DEBOUNCE_CYC.
- FSM outputs (state, mode_sel, cursor, inc/dec/clr strobes) update at e+4+DEBOUNCE_CYC.
- Holding a button produces exactly one press; there is no auto-repeat.
- cd_zero-to-DONE latency is 1 edge, and cd_run falls on that same edge.
- Strobe widths are exactly 1 cycle. Back-to-back presses are spaced by at least 2·DEBOUNCE_CYC.

## Structure
- Shared package clk_ctrl_pkg holds:
  - mode encodings MODE_CLOCK, MODE_ALARM, MODE_STOPWATCH, MODE_COUNTDOWN;
  - FSM encodings ST_VIEW, ST_EDIT, ST_RUN, ST_DONE;
  - digit indices DIG_SEC1…DIG_HR10;
  - NUM_DIGITS=6.
- Sub-module btn_debounce (synchronizer, counter, press strobe), instantiated seven times. The FSM and blink generator live in the top.

## Test plan
Bench uses DEBOUNCE_CYC=4, BLINK_DIV=8.
- Hold mode for 20 cycles after reset → mode_sel 0→1 exactly once, 8 edges after the raw rise. Three more presses → mode_sel 1→2→3→0.
- mode_sel=3: modify, left×6, up, right, down → cursor ends 0 after wrap; inc_pulse=6'b000001 for one cycle; after right, cursor=5 and dec_pulse=6'b100000.
- COUNTDOWN with cd_zero=0: start → cd_run=1. Force cd_zero=1 → next edge cd_run=0, cd_done=1, blink_mask toggles 000000/111111 every 8 cycles. Press up → VIEW, cd_done=0.
- STOPWATCH: modify ignored (edit stays 0); start → sw_run=1; start → sw_run=0; down → sw_clr high for exactly one cycle.
- Raw start and modify rise on the same edge in COUNTDOWN VIEW → RUN entered, no EDIT. A 2-cycle glitch on up produces no press.
- Assert reset for 1 cycle during RUN/EDIT → all outputs 0, VIEW. A button held across reset yields one press 7 edges after release of reset.
